// File: rtl/delay_reg_drain_pkg.sv
// ----------------------------------------------------------------------------
// delay_reg_drain_pkg
//   Default geometry for the read-side controller of the SHA datapath's
//   enable-gated RAM delay line. The instantiating round module normally
//   overrides WIDTH and DEPTH. These values are only the stand-alone defaults.
// ----------------------------------------------------------------------------
package delay_reg_drain_pkg;

  localparam int unsigned DRAIN_WIDTH      = 64;  // delay line / FIFO data width
  localparam int unsigned DRAIN_DEPTH      = 7;   // delay line depth (>= 2)
  localparam int unsigned DRAIN_FIFO_DEPTH = 4;   // output FIFO entries (power of 2)

endpackage : delay_reg_drain_pkg

// File: rtl/drain_fifo.sv
// ----------------------------------------------------------------------------
// drain_fifo
//   First-word fall-through register FIFO that catches real words leaving the
//   delay line. The head entry is always visible on dout. A push while full
//   and a pop while empty are ignored.
//
// Ports
//   clock  in   1          sole clock
//   rst    in   1          synchronous reset, active-high
//   push   in   1          write din at the tail
//   pop    in   1          retire the head entry
//   din    in   WIDTH      tail data
//   dout   out  WIDTH      head data (valid when !empty)
//   count  out  FIFO_AW+1  number of occupied entries
//   full   out  1          count == 2**FIFO_AW
//   empty  out  1          count == 0
// ----------------------------------------------------------------------------
module drain_fifo
  import delay_reg_drain_pkg::*;
#(
  parameter int unsigned WIDTH   = DRAIN_WIDTH,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam logic [FIFO_AW:0] CAPACITY = {1'b1, {FIFO_AW{1'b0}}};

  logic [WIDTH-1:0]   mem [1 << FIFO_AW];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CAPACITY);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally at 2**FIFO_AW. The extra count bit tells full from empty.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate its visibility,
  // and leaving it reset-free lets it map onto plain flops or LUT-RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule : drain_fifo

// File: rtl/delay_reg_drain.sv
// ----------------------------------------------------------------------------
// delay_reg_drain
//   Read-side controller for an enable-gated RAM delay line. It offers the
//   producer a valid/ready port and drives the delay line's enable. A tag
//   shift register marks which delay-line slots hold real words and which
//   hold bubbles. Real words leaving the line are caught in a FWFT FIFO that
//   serves a valid/ready consumer. Producer data bypasses this block and
//   feeds the delay line directly.
//
// Ports
//   clock        in   1      sole clock
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      producer presents a word at the delay-line input
//   in_ready     out  1      word accepted when in_valid & in_ready
//   pipe_enable  out  1      delay-line enable
//   pipe_data    in   WIDTH  delay-line data_out
//   out_data     out  WIDTH  FIFO head
//   out_valid    out  1      FIFO non-empty
//   out_ready    in   1      pop on out_valid & out_ready
// ----------------------------------------------------------------------------
module delay_reg_drain
  import delay_reg_drain_pkg::*;
#(
  parameter int unsigned WIDTH      = DRAIN_WIDTH,
  parameter int unsigned DEPTH      = DRAIN_DEPTH,
  parameter int unsigned FIFO_DEPTH = DRAIN_FIFO_DEPTH,
  parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pipe_enable,
  input  logic [WIDTH-1:0] pipe_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [DEPTH-1:0] tag;          // tag[DEPTH-1] qualifies pipe_data
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic             push;
  logic             pop;

  // Full is taken from the registered count. A pop in the same cycle does not
  // make room, which keeps out_ready off the combinational path to in_ready.
  // The line may advance whenever its head is a bubble, even when the FIFO is full.
  assign in_ready    = !rst && (!fifo_full || !tag[DEPTH-1]);

  // Advance only for a new word or to flush words still in flight.
  assign pipe_enable = in_ready && (in_valid || (|tag));

  // Bubbles reaching the head are dropped. Only tagged words are pushed.
  assign push        = pipe_enable && tag[DEPTH-1];
  assign out_valid   = !rst && (fifo_count != '0);
  assign pop         = !rst && out_ready && !fifo_empty;

  // The tags move in lock-step with the delay line. After reset all tags
  // are clear, so any stale RAM contents in the line are never pushed.
  always_ff @(posedge clock) begin
    if (rst) begin
      tag <= '0;
    end else if (pipe_enable) begin
      tag <= {tag[DEPTH-2:0], in_valid & in_ready};
    end
  end

  drain_fifo #(
    .WIDTH   (WIDTH),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pipe_data),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule : delay_reg_drain

// File: tb/tb_delay_reg_drain.sv
// ----------------------------------------------------------------------------
// tb_delay_reg_drain
//   Pairs delay_reg_drain with a behavioural enable-gated delay line. Checks
//   the DUT every cycle against a queue-level reference model. Scenario tasks
//   add their own directed checks.
// ----------------------------------------------------------------------------
module tb_delay_reg_drain;
  import delay_reg_drain_pkg::*;

  localparam int WIDTH      = 64;
  localparam int DEPTH      = 7;
  localparam int FIFO_DEPTH = 4;

  logic             clock     = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             pipe_enable;
  logic [WIDTH-1:0] pipe_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clock = ~clock;

  delay_reg_drain #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pipe_enable (pipe_enable),
    .pipe_data   (pipe_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Behavioural delay line. It has no reset, so stale contents survive a DUT reset.
  logic [WIDTH-1:0] dl [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) dl[i] = 64'hDEAD_0000 + 64'(i);
  always @(posedge clock) begin
    if (pipe_enable === 1'b1) begin
      dl[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end
  end
  assign pipe_data = dl[DEPTH-1];

  // Reference model. line_q holds DEPTH slots (front = newest, back = next out).
  // fifo_q holds the words waiting for the consumer.
  typedef struct {
    bit               is_word;
    logic [WIDTH-1:0] data;
  } slot_t;

  slot_t            line_q[$];
  logic [WIDTH-1:0] fifo_q[$];

  initial for (int i = 0; i < DEPTH; i++) line_q.push_front(slot_t'{is_word: 1'b0, data: '0});

  function automatic bit m_any();
    foreach (line_q[i]) if (line_q[i].is_word) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_head();
    return line_q[$].is_word;
  endfunction

  function automatic bit m_in_ready();
    return (rst == 1'b0) && !(fifo_q.size() == FIFO_DEPTH && m_head());
  endfunction

  always @(posedge clock) begin : model
    slot_t head;
    bit    ir, en, pp;
    if (rst) begin
      line_q.delete();
      for (int i = 0; i < DEPTH; i++) line_q.push_front(slot_t'{is_word: 1'b0, data: '0});
      fifo_q.delete();
    end else begin
      ir = m_in_ready();
      en = ir && (in_valid || m_any());
      pp = (fifo_q.size() != 0) && out_ready;
      if (pp) void'(fifo_q.pop_front());
      if (en) begin
        head = line_q.pop_back();
        if (head.is_word) fifo_q.push_back(head.data);
        line_q.push_front(slot_t'{is_word: in_valid, data: in_data});
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clock) begin : monitor
    bit e_ir, e_en, e_ov;
    if (mon_en) begin
      e_ir = m_in_ready();
      e_en = e_ir && (in_valid || m_any());
      e_ov = (rst == 1'b0) && (fifo_q.size() != 0);
      n_cmp++;
      if (in_ready !== e_ir) begin
        n_bad++;
        $display("FAIL mon_in_ready t=%0t got=%b expected=%b", $time, in_ready, e_ir);
      end
      n_cmp++;
      if (pipe_enable !== e_en) begin
        n_bad++;
        $display("FAIL mon_pipe_enable t=%0t got=%b expected=%b", $time, pipe_enable, e_en);
      end
      n_cmp++;
      if (out_valid !== e_ov) begin
        n_bad++;
        $display("FAIL mon_out_valid t=%0t got=%b expected=%b", $time, out_valid, e_ov);
      end
      if (e_ov) begin
        n_cmp++;
        if (out_data !== fifo_q[0]) begin
          n_bad++;
          $display("FAIL mon_out_data t=%0t got=%h expected=%h", $time, out_data, fifo_q[0]);
        end
      end
      n_cmp++;
      if (pipe_enable === 1'b1 && fifo_q.size() == FIFO_DEPTH && m_head()) begin
        n_bad++;
        $display("FAIL mon_frozen_when_full t=%0t got pipe_enable=1 expected 0", $time);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #3;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b expected=0", in_ready); end
    n_cmp++;
    if (pipe_enable !== 1'b0) begin n_bad++; $display("FAIL reset_pipe_enable got=%b expected=0", pipe_enable); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    #3;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got=%b expected=1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_valid got=%b expected=0", out_valid); end
    next_cycle();
  endtask

  task automatic test_stream();
    int first = -1;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_valid = (k < 30);
      in_data  = WIDTH'(k + 1);
      #3;
      if (out_valid === 1'b1 && first < 0) first = k;
      if (first >= 0 && k < first + 30) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== WIDTH'(k - first + 1)) begin
          n_bad++;
          $display("FAIL stream_word k=%0d got valid=%b data=%0h expected valid=1 data=%0h",
                   k, out_valid, out_data, k - first + 1);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (first != DEPTH + 1) begin
      n_bad++;
      $display("FAIL stream_latency got=%0d expected=%0d", first, DEPTH + 1);
    end
  endtask

  task automatic test_single();
    int               en_cnt = 0;
    int               beats  = 0;
    logic [WIDTH-1:0] last   = '0;
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      in_valid = (k == 0);
      in_data  = (k == 0) ? WIDTH'(8'hA5) : {$urandom, $urandom};
      #3;
      if (pipe_enable === 1'b1) en_cnt++;
      if (out_valid === 1'b1) begin beats++; last = out_data; end
      next_cycle();
    end
    #3;
    n_cmp++;
    if (en_cnt != DEPTH + 1) begin n_bad++; $display("FAIL single_enable_cycles got=%0d expected=%0d", en_cnt, DEPTH + 1); end
    n_cmp++;
    if (beats != 1) begin n_bad++; $display("FAIL single_beats got=%0d expected=1", beats); end
    n_cmp++;
    if (last !== WIDTH'(8'hA5)) begin n_bad++; $display("FAIL single_data got=%h expected=a5", last); end
    n_cmp++;
    if (pipe_enable !== 1'b0) begin n_bad++; $display("FAIL single_idle_enable got=%b expected=0", pipe_enable); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    int               sent = 0;
    logic [WIDTH-1:0] got[$];
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(sent + 1);
      #3;
      if (in_ready === 1'b1) sent++;
      next_cycle();
    end
    #3;
    // Four words sit in the FIFO and the line is packed with seven more.
    n_cmp++;
    if (sent != FIFO_DEPTH + DEPTH) begin n_bad++; $display("FAIL bp_accepted got=%0d expected=%0d", sent, FIFO_DEPTH + DEPTH); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b expected=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(1)) begin
      n_bad++; $display("FAIL bp_head got valid=%b data=%0h expected valid=1 data=1", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      in_valid = (sent < 12);
      in_data  = WIDTH'(sent + 1);
      #3;
      if (in_valid && in_ready === 1'b1) sent++;
      if (out_valid === 1'b1) got.push_back(out_data);
      next_cycle();
    end
    n_cmp++;
    if (got.size() != 12) begin n_bad++; $display("FAIL bp_count got=%0d expected=12", got.size()); end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      n_cmp++;
      if (got[i] !== WIDTH'(i + 1)) begin n_bad++; $display("FAIL bp_order idx=%0d got=%0h expected=%0h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_bubbles();
    logic [WIDTH-1:0] acc[$];
    logic [WIDTH-1:0] got[$];
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = {$urandom, $urandom};
      #3;
      if (in_valid && in_ready === 1'b1) acc.push_back(in_data);
      next_cycle();
    end
    #3;
    // Words from even cycles 0..12 fill the FIFO and line. The FIFO is full
    // from cycle 14, but a bubble is then at the head, so the line still
    // advances and takes the word from cycle 14. Eight words in total.
    n_cmp++;
    if (acc.size() != 8) begin n_bad++; $display("FAIL bub_accepted got=%0d expected=8", acc.size()); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bub_in_ready got=%b expected=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1 || (acc.size() > 0 && out_data !== acc[0])) begin
      n_bad++; $display("FAIL bub_head got valid=%b data=%h expected valid=1", out_valid, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #3;
      if (out_valid === 1'b1) got.push_back(out_data);
      next_cycle();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (got.size() != acc.size()) begin n_bad++; $display("FAIL bub_count got=%0d expected=%0d", got.size(), acc.size()); end
    for (int i = 0; i < got.size() && i < acc.size(); i++) begin
      n_cmp++;
      if (got[i] !== acc[i]) begin n_bad++; $display("FAIL bub_order idx=%0d got=%h expected=%h", i, got[i], acc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int               first = -1;
    logic [WIDTH-1:0] fdata = '0;
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 7);
      in_data  = WIDTH'(8'h10 + k);
      next_cycle();
    end
    // Two words in the FIFO, five still in the line.
    in_valid = 1'b0;
    #3;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== WIDTH'(8'h10)) begin
      n_bad++; $display("FAIL mid_before got valid=%b data=%0h expected valid=1 data=10", out_valid, out_data);
    end
    next_cycle();
    rst = 1'b1;
    #3;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || pipe_enable !== 1'b0) begin
      n_bad++; $display("FAIL mid_during got valid=%b ready=%b enable=%b expected 0 0 0", out_valid, in_ready, pipe_enable);
    end
    next_cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k == 0);
      in_data  = (k == 0) ? WIDTH'(8'h77) : {$urandom, $urandom};
      #3;
      if (k == 0) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after got valid=%b expected=0", out_valid); end
      end
      if (out_valid === 1'b1 && first < 0) begin first = k; fdata = out_data; end
      next_cycle();
    end
    n_cmp++;
    if (first != DEPTH + 1) begin n_bad++; $display("FAIL mid_latency got=%0d expected=%0d", first, DEPTH + 1); end
    n_cmp++;
    if (fdata !== WIDTH'(8'h77)) begin n_bad++; $display("FAIL mid_first_word got=%h expected=77", fdata); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_w;
    int               in_pct;
    int               out_pct;
    apply_reset();
    for (int k = 0; k < 10000; k++) begin
      // Shift the traffic mix every 1000 cycles to visit full, empty and flowing.
      in_pct    = 20 + 15 * ((k / 1000) % 5);
      out_pct   = 90 - 20 * ((k / 1000) % 4);
      in_valid  = ($urandom_range(0, 99) < in_pct);
      out_ready = ($urandom_range(0, 99) < out_pct);
      in_data   = {$urandom, $urandom};
      #3;
      if (in_valid && in_ready === 1'b1) sb.push_back(in_data);
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rand_spurious k=%0d got=%h expected no word", k, out_data);
        end else begin
          exp_w = sb.pop_front();
          if (out_data !== exp_w) begin n_bad++; $display("FAIL rand_data k=%0d got=%h expected=%h", k, out_data, exp_w); end
        end
      end
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      #3;
      if (out_valid === 1'b1) begin
        n_cmp++;
        exp_w = sb.pop_front();
        if (out_data !== exp_w) begin n_bad++; $display("FAIL rand_drain got=%h expected=%h", out_data, exp_w); end
      end
      next_cycle();
    end
    #3;
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rand_leftover got=%0d words, valid=%b expected 0 words, valid=0", sb.size(), out_valid);
    end
    next_cycle();
  endtask

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_stream();
    test_single();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_delay_reg_drain
